jpeg_inverse_zigzag: RTL and testbench

Streaming inverse-zigzag reorder buffer for the decode direction of the JPEG path. It accepts Q16.16 coefficients in JPEG zigzag order, one per handshake. It buffers each 8x8 block in one of two ping-pong banks and streams the block out in raster order, so raster index r = row*8+col. It is the counterpart of the compression pipeline's zigzag output stage and feeds the dequant/IDCT chain.

---
 rtl/jpeg_inverse_zigzag.sv | 174 +++++++++++++++++
 tb/tb_jpeg_inverse_zigzag.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_inverse_zigzag.sv
// ---------------------------------------------------------------------------
// JpegInverseZigzag (module jpeg_inverse_zigzag)
//
// Streaming inverse-zigzag reorder buffer for the JPEG decode path. Each
// 8x8 block arrives in zigzag order and is written into one of two
// ping-pong banks at its raster position. A full bank is then streamed out
// in raster order (index = row*8 + col) while the other bank fills.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous, active-high reset
//   s_valid  - input coefficient valid
//   s_ready  - input can accept (low while the write bank is full or in reset)
//   s_data   - coefficient at zigzag index k of the current block
//   s_last   - marks zigzag index 63 (only checked with DEZIGZAG_ERR_EN)
//   m_valid  - output coefficient valid
//   m_ready  - downstream accepts
//   m_data   - coefficient at raster index m_index
//   m_index  - raster index of m_data, 0..63
//   m_last   - high with m_index == 63
//   err      - sticky framing error
//
// Optional feature macro: DEZIGZAG_ERR_EN
//   Enables s_last framing checks, early block close and a per-bank
//   written mask so unwritten raster positions read back as zero.
// ---------------------------------------------------------------------------
module jpeg_inverse_zigzag #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [5:0]            m_index,
   output logic                  m_last,
   output logic                  err
);

   // Zigzag position k maps to raster position ZZ[k].
   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   logic                  wr_bank;
   logic                  rd_bank;
   logic [5:0]            wr_cnt;
   logic [5:0]            rd_cnt;
   logic [1:0]            full;
   logic [1:0]            full_nxt;
   logic [DATA_WIDTH-1:0] bank_mem [0:127];
   logic [5:0]            zz_addr;
   logic                  accept;
   logic                  close_blk;
   logic                  load;
   logic                  free_blk;
   logic [DATA_WIDTH-1:0] rd_word;

   // Handshake decode. The write bank can never be the bank currently being
   // read (that one is full), so writes and reads never touch the same bank.
   assign s_ready  = !reset && !full[wr_bank];
   assign accept   = s_valid && s_ready;
   assign zz_addr  = 6'(ZZ[wr_cnt]);
   assign load     = full[rd_bank] && (!m_valid || m_ready);
   assign free_blk = load && (rd_cnt == 6'd63);

`ifdef DEZIGZAG_ERR_EN
   logic [1:0][63:0] written;

   // An early s_last closes the block just like the 64th coefficient does.
   assign close_blk = accept && ((wr_cnt == 6'd63) || s_last);
   assign rd_word   = written[rd_bank][rd_cnt] ? bank_mem[{rd_bank, rd_cnt}]
                                               : '0;

   // Track which raster slots of each bank hold real data so a block that
   // was closed early reads its missing positions as zero. A bank's mask is
   // wiped as it is handed back to the writer.
   always_ff @(posedge clk) begin
      if (reset) begin
         written <= '0;
      end else begin
         if (free_blk)
            written[rd_bank] <= '0;
         if (accept)
            written[wr_bank][zz_addr] <= 1'b1;
      end
   end

   // Sticky framing error: s_last must be present exactly on zigzag index 63.
   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else if (accept && (s_last != (wr_cnt == 6'd63)))
         err <= 1'b1;
   end
`else
   logic last_unused;

   // Without framing checks a block always closes on its 64th coefficient.
   assign close_blk   = accept && (wr_cnt == 6'd63);
   assign rd_word     = bank_mem[{rd_bank, rd_cnt}];
   assign err         = 1'b0;
   assign last_unused = s_last;
`endif

   // Bank occupancy: a write can complete one bank while a read frees the
   // other on the same edge, so both updates are applied independently.
   always_comb begin
      full_nxt = full;
      if (close_blk)
         full_nxt[wr_bank] = 1'b1;
      if (free_blk)
         full_nxt[rd_bank] = 1'b0;
   end

   // Coefficient storage, written at the raster slot of the incoming
   // zigzag index. No reset: stale contents are never read before rewrite.
   always_ff @(posedge clk) begin
      if (accept)
         bank_mem[{wr_bank, zz_addr}] <= s_data;
   end

   // Write-side bookkeeping: count coefficients and flip banks on close.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
         full    <= '0;
      end else begin
         full <= full_nxt;
         if (close_blk) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
         end else if (accept) begin
            wr_cnt <= wr_cnt + 6'd1;
         end
      end
   end

   // Read side and output register. A new coefficient loads whenever the
   // register is empty or being consumed; otherwise a consumed value just
   // drops m_valid and the payload fields hold their last values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_bank <= 1'b0;
         rd_cnt  <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_index <= '0;
         m_last  <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= rd_word;
         m_index <= rd_cnt;
         m_last  <= (rd_cnt == 6'd63);
         if (free_blk) begin
            rd_cnt  <= '0;
            rd_bank <= ~rd_bank;
         end else begin
            rd_cnt <= rd_cnt + 6'd1;
         end
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jpeg_inverse_zigzag.sv
// ---------------------------------------------------------------------------
// Self-checking bench for jpeg_inverse_zigzag. Expected output blocks are
// built from a zigzag table derived by walking the anti-diagonals of an
// 8x8 grid, then compared against the DUT output stream.
// ---------------------------------------------------------------------------
module tb_jpeg_inverse_zigzag;

   localparam int DW = 32;
`ifdef DEZIGZAG_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic [5:0]    m_index;
   logic          m_last;
   logic          err;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [5:0]    i;
      logic          l;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          held;
   bit            hold_pending = 0;
   int            zz_ref[64];
   int            checks = 0;
   int            errors = 0;
   int            cycle = 0;
   int            pop_count = 0;
   int            first_cycle = 0;
   int            last_cycle = 0;
   int            stall_cycles = 0;
   int            rdy_mode = 0;
   bit            capture = 0;
   logic [DW-1:0] cap[64];

   jpeg_inverse_zigzag #(.DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_index (m_index),
      .m_last  (m_last),
      .err     (err)
   );

   // Free-running clock and a cycle counter for throughput checks.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'b0;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor: sampled mid-cycle; a transfer happens on the next
   // rising edge when m_valid && m_ready. Stalled outputs must hold.
   always @(negedge clk) begin
      exp_t e;
      if (hold_pending) begin
         checkOutput("hold_valid", m_valid, 1);
         checkOutput("hold_data", m_data, held.d);
         checkOutput("hold_index", m_index, held.i);
         checkOutput("hold_last", m_last, held.l);
      end
      hold_pending = 0;
      if (!reset && m_valid) begin
         if (!m_ready) begin
            hold_pending = 1;
            held = '{d: m_data, i: m_index, l: m_last};
         end else if (exp_q.size() == 0) begin
            checkOutput("extra_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", m_data, e.d);
            checkOutput("out_index", m_index, e.i);
            checkOutput("out_last", m_last, e.l);
            if (pop_count == 0)
               first_cycle = cycle;
            last_cycle = cycle;
            pop_count++;
            if (capture)
               cap[m_index] = m_data;
         end
      end
   end

   // Feed n coefficients of one block. Data is either tag*1000+k or random.
   // A block that closes (64 words, or early s_last with framing checks on)
   // has its raster-order image pushed to the expected queue.
   task automatic applyStimulus(input int n, input bit last_at_end,
                                input bit rand_data, input int tag);
      logic [DW-1:0] vals[64];
      logic [DW-1:0] raster[64];
      exp_t          e;
      int            budget;
      for (int k = 0; k < n; k++) begin
         vals[k] = rand_data ? DW'($urandom) : DW'(tag * 1000 + k);
         s_valid = 1'b1;
         s_data  = vals[k];
         s_last  = last_at_end && (k == n - 1);
         budget  = 2000;
         @(negedge clk);
         while (!s_ready && budget > 0) begin
            stall_cycles++;
            budget--;
            @(negedge clk);
         end
         if (budget == 0) begin
            checkOutput("s_ready_timeout", 0, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (n == 64 || (ERR_EN && last_at_end)) begin
         for (int r = 0; r < 64; r++)
            raster[r] = '0;
         for (int k = 0; k < n; k++)
            raster[zz_ref[k]] = vals[k];
         for (int r = 0; r < 64; r++) begin
            e = '{d: raster[r], i: 6'(r), l: (r == 63)};
            exp_q.push_back(e);
         end
      end
   endtask

   // Wait until every expected coefficient has left the DUT.
   task automatic waitDrain();
      int budget = 4000;
      while (budget > 0 && !(exp_q.size() == 0 && !m_valid)) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0)
         checkOutput("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int kk;
      int row;
      int col;

      // Zigzag order: walk anti-diagonals s = row+col, rows ascending on
      // odd diagonals and descending on even ones.
      kk = 0;
      for (int s = 0; s < 15; s++) begin
         for (int t = 0; t < 8; t++) begin
            row = (s % 2 == 1) ? t : 7 - t;
            col = s - row;
            if (col >= 0 && col < 8) begin
               zz_ref[kk] = row * 8 + col;
               kk++;
            end
         end
      end

      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_m_valid", m_valid, 0);
      checkOutput("reset_m_data", m_data, 0);
      checkOutput("reset_m_index", m_index, 0);
      checkOutput("reset_m_last", m_last, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_s_ready", s_ready, 0);
      reset = 1'b0;
      #1;
      checkOutput("ready_after_reset", s_ready, 1);

      // Single block with data = zigzag index; checks latency and mapping.
      capture   = 1;
      pop_count = 0;
      applyStimulus(64, 1, 0, 0);
      checkOutput("latency_not_yet", m_valid, 0);
      @(posedge clk);
      #1;
      checkOutput("latency_valid", m_valid, 1);
      checkOutput("latency_index", m_index, 0);
      waitDrain();
      capture = 0;
      checkOutput("blk0_count", pop_count, 64);
      checkOutput("raster0", cap[0], 0);
      checkOutput("raster1", cap[1], 1);
      checkOutput("raster8", cap[8], 2);
      checkOutput("raster16", cap[16], 3);
      checkOutput("raster2", cap[2], 5);
      checkOutput("raster63", cap[63], 63);

      // Three back-to-back blocks: no input stalls, contiguous output.
      pop_count    = 0;
      stall_cycles = 0;
      for (int b = 0; b < 3; b++)
         applyStimulus(64, 1, 0, b);
      waitDrain();
      checkOutput("b2b_stalls", stall_cycles, 0);
      checkOutput("b2b_count", pop_count, 192);
      checkOutput("b2b_contiguous", last_cycle - first_cycle, 191);

      // Consumer stalled: both banks fill, then release.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      stall_cycles = 0;
      applyStimulus(64, 1, 1, 0);
      applyStimulus(64, 1, 1, 0);
      checkOutput("stall_s_ready_low", s_ready, 0);
      checkOutput("stall_m_valid", m_valid, 1);
      checkOutput("stall_m_index", m_index, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_still_low", s_ready, 0);
      fork
         applyStimulus(64, 1, 1, 0);
         begin
            repeat (10) @(posedge clk);
            rdy_mode = 0;
         end
      join
      waitDrain();
      checkOutput("stall_seen", stall_cycles > 0, 1);

      // Random downstream backpressure over four random blocks.
      rdy_mode = 2;
      for (int b = 0; b < 4; b++)
         applyStimulus(64, 1, 1, 0);
      waitDrain();
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // Reset while block 0 is mid-read and block 1 is mid-write.
      applyStimulus(64, 1, 1, 0);
      applyStimulus(30, 0, 1, 0);
      checkOutput("pre_reset_busy", m_valid, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_m_valid", m_valid, 0);
      checkOutput("midreset_m_data", m_data, 0);
      checkOutput("midreset_m_index", m_index, 0);
      checkOutput("midreset_m_last", m_last, 0);
      checkOutput("midreset_s_ready", s_ready, 0);
      exp_q.delete();
      reset = 1'b0;
      applyStimulus(64, 1, 1, 5);
      waitDrain();

`ifdef DEZIGZAG_ERR_EN
      // Early s_last at zigzag index 9: block closes short, err sticks.
      applyStimulus(10, 1, 1, 0);
      checkOutput("err_set", err, 1);
      waitDrain();
      applyStimulus(64, 1, 1, 0);
      waitDrain();
      checkOutput("err_sticky", err, 1);
`else
      checkOutput("err_tied_low", err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
